frame_buffer: RTL



---
 rtl/frame_buffer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/frame_buffer.sv
`default_nettype none
// ============================================================================
// frame_buffer : ping-pong frame buffer, two DEPTH-sample banks streamed out
//                over valid/ready with a last-beat marker.
// Option       : define FRAME_BUFFER_DROP_CNT_EN for the saturating drop counter.
// Revision     : 1.0
// ============================================================================
module frame_buffer #(
  parameter int W     = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic         in_clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         overflow,
  output logic [15:0]  drop_cnt
);

  localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  logic [W-1:0]  mem [2*DEPTH];

  logic [1:0]    full_q;
  logic [1:0]    full_d;
  logic          wr_bank_q;
  logic [AW-1:0] wr_idx_q;
  logic          overflow_q;

  state_t        state_q;
  logic          rd_bank_q;
  logic [AW-1:0] rd_idx_q;
  logic [W-1:0]  out_data_q;
  logic          out_valid_q;
  logic          out_last_q;

  logic          w_wr_fire;
  logic          w_wr_drop;
  logic          w_wr_done;
  logic          w_hs;
  logic          w_rd_done;
  logic          w_rd_en;
  logic [AW:0]   w_rd_addr;

  always_comb begin
    w_wr_fire = in_valid && !full_q[wr_bank_q];
    w_wr_drop = in_valid &&  full_q[wr_bank_q];
    w_wr_done = w_wr_fire && (wr_idx_q == c_last_idx);
    w_hs      = out_valid_q && out_ready;
    w_rd_done = w_hs && out_last_q;

    // Prefetch the next index on every non-final handshake so beats stream without bubbles.
    w_rd_en   = 1'b0;
    w_rd_addr = {rd_bank_q, {AW{1'b0}}};
    if (state_q == S_IDLE) begin
      w_rd_en = full_q[rd_bank_q];
    end else if (w_hs && !out_last_q) begin
      w_rd_en   = 1'b1;
      w_rd_addr = {rd_bank_q, rd_idx_q + AW'(1)};
    end

    full_d = full_q;
    if (w_wr_done) full_d[wr_bank_q] = 1'b1;
    if (w_rd_done) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge in_clk) begin
    if (w_wr_fire) mem[{wr_bank_q, wr_idx_q}] <= in_data;
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (w_wr_fire) begin
        wr_idx_q <= w_wr_done ? '0 : wr_idx_q + AW'(1);
        if (w_wr_done) wr_bank_q <= ~wr_bank_q;
      end
      if (w_wr_drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (full_q[rd_bank_q]) begin
            rd_idx_q    <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            if (out_last_q) begin
              rd_bank_q   <= ~rd_bank_q;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              rd_idx_q   <= rd_idx_q + AW'(1);
              out_last_q <= ((rd_idx_q + AW'(1)) == c_last_idx);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      out_data_q <= '0;
    end else if (w_rd_en) begin
      out_data_q <= mem[w_rd_addr];
    end
  end

`ifdef FRAME_BUFFER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge in_clk) begin
    if (rst) begin
      drop_cnt_q <= 16'h0000;
    end else if (w_wr_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire
